// File: rtl/pin_ctrl_pkg.sv
// Shared types and widths for the pin transaction controller.
package pin_ctrl_pkg;

    localparam int PIN_W = 8;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        TURN,
        SAMPLE,
        RESP
    } state_t;

    typedef struct packed {
        logic             write;
        logic [PIN_W-1:0] data;
        logic             err;
    } rsp_t;

endpackage

// File: rtl/pin_ctrl_timer.sv
// Loadable down-counter that stops at zero; one instance is reused for the
// drive-hold, turnaround and sample-delay phases.
module pin_ctrl_timer
    import pin_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] value_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;
    assign done_o  = (cnt_q == '0);

endmodule

// File: rtl/pin_ctrl.sv
// Sequences single-beat read/write requests onto the bidirectional pin stage.
// Define PIN_CTRL_WRITE_VERIFY_EN to flag writes whose loopback value differs.
//
// state  | meaning
// IDLE   | bus released, ready for a request
// DRIVE  | direction=1, data_write held for HOLD_CYCLES
// TURN   | bus released, waiting for the line to settle
// SAMPLE | waiting for the pin's input register before capture
// RESP   | response presented until rsp_ready
module pin_ctrl
    import pin_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES  = 2,
    parameter int TURN_CYCLES  = 1,
    parameter int SAMPLE_DELAY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [PIN_W-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_write,
    output logic [PIN_W-1:0] rsp_data,
    output logic             rsp_err,
    output logic             direction,
    output logic [PIN_W-1:0] data_write,
    input  logic [PIN_W-1:0] data_read,
    output logic             busy
);

    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_DELAY - 1);

    state_t           state_q, state_d;
    logic             direction_q, direction_d;
    logic [PIN_W-1:0] data_write_q, data_write_d;
    rsp_t             rsp_q, rsp_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_done;
    logic [CNT_W-1:0] tmr_value_unused;
    logic             verify_err;

`ifdef PIN_CTRL_WRITE_VERIFY_EN
    // The loopback passes through the pin's input register, so one hold cycle
    // cannot show the driven byte yet.
    if (HOLD_CYCLES < 2) begin : g_hold_chk
        $error("pin_ctrl: write verify needs HOLD_CYCLES >= 2");
    end
    assign verify_err = (data_read != data_write_q);
`else
    assign verify_err = 1'b0;
`endif

    pin_ctrl_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .value_o    (tmr_value_unused),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d      = state_q;
        direction_d  = direction_q;
        data_write_d = data_write_q;
        rsp_d        = rsp_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tmr_load = 1'b1;
                    if (req_write) begin
                        data_write_d = req_data;
                        direction_d  = 1'b1;
                        tmr_load_val = HOLD_LD;
                        state_d      = DRIVE;
                    end else begin
                        tmr_load_val = TURN_LD;
                        state_d      = TURN;
                    end
                end
            end
            DRIVE: begin
                if (tmr_done) begin
                    direction_d = 1'b0;
                    rsp_d       = '{write: 1'b1, data: data_write_q, err: verify_err};
                    state_d     = RESP;
                end
            end
            TURN: begin
                if (tmr_done) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = SAMPLE_LD;
                    state_d      = SAMPLE;
                end
            end
            SAMPLE: begin
                if (tmr_done) begin
                    rsp_d   = '{write: 1'b0, data: data_read, err: 1'b0};
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            direction_q  <= 1'b0;
            data_write_q <= '0;
            rsp_q        <= '0;
        end else begin
            state_q      <= state_d;
            direction_q  <= direction_d;
            data_write_q <= data_write_d;
            rsp_q        <= rsp_d;
        end
    end

    assign req_ready  = (state_q == IDLE) && rst_n;
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign direction  = direction_q;
    assign data_write = data_write_q;
    assign rsp_write  = rsp_q.write;
    assign rsp_data   = rsp_q.data;
    assign rsp_err    = rsp_q.err;

endmodule
